// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C CSR block: register map, COMMAND bits,
// status_i and event_i bit positions.
package apb_i2c_pkg;

  localparam logic [7:0] OFS_TRANSMIT   = 8'h00;
  localparam logic [7:0] OFS_RECEIVE    = 8'h04;
  localparam logic [7:0] OFS_STATUS     = 8'h08;
  localparam logic [7:0] OFS_SLAVE_ADDR = 8'h0C;
  localparam logic [7:0] OFS_COMMAND    = 8'h10;
  localparam logic [7:0] OFS_PRESCALE   = 8'h14;
  localparam logic [7:0] OFS_INT_STATUS = 8'h18;
  localparam logic [7:0] OFS_INT_ENABLE = 8'h1C;

  // Word index of each register, i.e. offset >> 2.
  typedef enum logic [2:0] {
    REG_TRANSMIT   = 3'd0,
    REG_RECEIVE    = 3'd1,
    REG_STATUS     = 3'd2,
    REG_SLAVE_ADDR = 3'd3,
    REG_COMMAND    = 3'd4,
    REG_PRESCALE   = 3'd5,
    REG_INT_STATUS = 3'd6,
    REG_INT_ENABLE = 3'd7
  } reg_idx_e;

  localparam int CMD_START_BIT = 6;
  localparam int CMD_RESET_BIT = 7;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;

  localparam int NUM_EVENTS   = 4;
  localparam int EVT_TX_EMPTY = 0;
  localparam int EVT_RX_FULL  = 1;
  localparam int EVT_NACK     = 2;
  localparam int EVT_ARB_LOST = 3;

endpackage

// File: rtl/apb_i2c_csr_if.sv
// APB bus bundle for the I2C CSR block, with master and slave views.
// A transfer completes on the edge where psel, penable and pready are all 1.
interface apb_i2c_csr_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  pclk, prdata, pready, pslverr,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    input  pclk, paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/i2c_irq_ctrl.sv
// INT_STATUS / INT_ENABLE registers and the interrupt line.
// irq_o is built purely from flops so no input reaches it combinationally.
module i2c_irq_ctrl
  import apb_i2c_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  status_we_i,
  input  logic                  enable_we_i,
  input  logic [NUM_EVENTS-1:0] wdata_i,
  output logic [NUM_EVENTS-1:0] int_status_o,
  output logic [NUM_EVENTS-1:0] int_enable_o,
  output logic                  irq_o
);
  logic [NUM_EVENTS-1:0] status_q, status_d;
  logic [NUM_EVENTS-1:0] enable_q, enable_d;

  // New events are OR-ed in after the W1C so a simultaneous set wins.
  always_comb begin
    status_d = status_q;
    if (status_we_i) status_d = status_d & ~wdata_i;
    status_d = status_d | event_i;
    enable_d = enable_we_i ? wdata_i : enable_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
      enable_q <= '0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
    end
  end

  assign int_status_o = status_q;
  assign int_enable_o = enable_q;
  assign irq_o        = |(status_q & enable_q);
endmodule

// File: rtl/apb_i2c_csr.sv
// APB slave CSR front-end of an I2C master core: register map, FIFO strobes,
// command handshakes with the core, and wait states on RECEIVE reads.
module apb_i2c_csr
  import apb_i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_WAIT    = 2
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic [7:0]            status_i,
  input  logic [7:0]            rx_data_i,
  input  logic [3:0]            event_i,
  input  logic                  start_done_i,
  input  logic                  reset_done_i,
  output logic                  tx_winc_o,
  output logic [7:0]            tx_data_o,
  output logic                  rx_rinc_o,
  output logic [7:0]            slave_addr_o,
  output logic [7:0]            command_o,
  output logic [7:0]            prescale_o,
  output logic                  irq_o
);
  logic [ADDR_WIDTH:0] addr_ext;
  logic                addr_ok, access, rx_read, complete, err, wr_ok, rd_ok;
  reg_idx_e            idx;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic [7:0]          slave_q, command_q, command_d, prescale_q, tx_data_q;
  logic                tx_winc_q, rx_rinc_q;
  logic [7:0]          rdata8;
  logic [3:0]          int_status, int_enable;
  logic                unused_pwdata;

  // One extra bit so the 0x20 bound is representable at ADDR_WIDTH = 5.
  assign addr_ext = {1'b0, paddr_i};
  assign addr_ok  = (addr_ext < (ADDR_WIDTH+1)'(32)) && (paddr_i[1:0] == 2'b00);
  assign idx      = reg_idx_e'(paddr_i[4:2]);
  assign access   = psel_i & penable_i & ~preset_i;
  assign rx_read  = access & ~pwrite_i & addr_ok & (idx == REG_RECEIVE);
  assign complete = access & (~rx_read | (wait_cnt_q == 2'(RD_WAIT)));

  always_comb begin
    err = 1'b0;
    if (!addr_ok) err = 1'b1;
    else if (pwrite_i) begin
      if (idx == REG_RECEIVE || idx == REG_STATUS) err = 1'b1;
      if (idx == REG_TRANSMIT && status_i[STAT_TX_FULL]) err = 1'b1;
    end else if (idx == REG_RECEIVE && status_i[STAT_RX_EMPTY]) err = 1'b1;
  end

  assign wr_ok = complete & pwrite_i & ~err;
  assign rd_ok = complete & ~pwrite_i & ~err;

  always_comb begin
    case (idx)
      REG_RECEIVE:    rdata8 = rx_data_i;
      REG_STATUS:     rdata8 = status_i;
      REG_SLAVE_ADDR: rdata8 = slave_q;
      REG_COMMAND:    rdata8 = command_q;
      REG_PRESCALE:   rdata8 = prescale_q;
      REG_INT_STATUS: rdata8 = {4'b0, int_status};
      REG_INT_ENABLE: rdata8 = {4'b0, int_enable};
      default:        rdata8 = 8'h00;
    endcase
  end

  // APB write wins over the core's done handshakes.
  always_comb begin
    command_d = command_q;
    if (start_done_i) command_d[CMD_START_BIT] = 1'b0;
    if (reset_done_i) command_d[CMD_RESET_BIT] = 1'b0;
    if (wr_ok && idx == REG_COMMAND) command_d = pwdata_i[7:0];
    wait_cnt_d = wait_cnt_q;
    if (!psel_i || complete) wait_cnt_d = 2'd0;
    else if (rx_read)        wait_cnt_d = wait_cnt_q + 2'd1;
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      wait_cnt_q <= '0;
      slave_q    <= '0;
      command_q  <= '0;
      prescale_q <= '0;
      tx_data_q  <= '0;
      tx_winc_q  <= 1'b0;
      rx_rinc_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      command_q  <= command_d;
      if (wr_ok && idx == REG_SLAVE_ADDR) slave_q    <= pwdata_i[7:0];
      if (wr_ok && idx == REG_PRESCALE)   prescale_q <= pwdata_i[7:0];
      if (wr_ok && idx == REG_TRANSMIT)   tx_data_q  <= pwdata_i[7:0];
      tx_winc_q <= wr_ok & (idx == REG_TRANSMIT);
      rx_rinc_q <= rd_ok & (idx == REG_RECEIVE);
    end
  end

  i2c_irq_ctrl u_irq (
    .clk_i        (pclk_i),
    .rst_i        (preset_i),
    .event_i      (event_i),
    .status_we_i  (wr_ok & (idx == REG_INT_STATUS)),
    .enable_we_i  (wr_ok & (idx == REG_INT_ENABLE)),
    .wdata_i      (pwdata_i[3:0]),
    .int_status_o (int_status),
    .int_enable_o (int_enable),
    .irq_o        (irq_o)
  );

  assign unused_pwdata = ^(pwdata_i >> 8);
  assign prdata_o      = rd_ok ? DATA_WIDTH'(rdata8) : '0;
  assign pready_o      = complete;
  assign pslverr_o     = complete & err;
  assign tx_winc_o     = tx_winc_q;
  assign tx_data_o     = tx_data_q;
  assign rx_rinc_o     = rx_rinc_q;
  assign slave_addr_o  = slave_q;
  assign command_o     = command_q;
  assign prescale_o    = prescale_q;
endmodule

// File: tb/tb_apb_i2c_csr.sv
// Bench for apb_i2c_csr: directed scenarios plus randomized transfers checked
// against a register-map model held in plain variables.
module tb_apb_i2c_csr;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RD_WAIT = 2;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  apb_i2c_csr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.pclk(pclk));

  logic       preset;
  logic [7:0] status, rx_data;
  logic [3:0] evt;
  logic       sd, rd;
  logic       tx_winc, rx_rinc, irq;
  logic [7:0] tx_data, slave_addr, command, prescale;

  apb_i2c_csr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WAIT(RD_WAIT)) dut (
    .pclk_i(pclk), .preset_i(preset),
    .paddr_i(bus.paddr), .psel_i(bus.psel), .penable_i(bus.penable),
    .pwrite_i(bus.pwrite), .pwdata_i(bus.pwdata), .prdata_o(bus.prdata),
    .pready_o(bus.pready), .pslverr_o(bus.pslverr),
    .status_i(status), .rx_data_i(rx_data), .event_i(evt),
    .start_done_i(sd), .reset_done_i(rd),
    .tx_winc_o(tx_winc), .tx_data_o(tx_data), .rx_rinc_o(rx_rinc),
    .slave_addr_o(slave_addr), .command_o(command), .prescale_o(prescale),
    .irq_o(irq)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model of the register file
  logic [7:0] m_slave, m_cmd, m_pre, m_txd;
  logic [3:0] m_ist, m_ien;

  // One APB transfer: setup, access, bounded wait, then one idle cycle in
  // which the post-completion strobes are sampled.
  task automatic apb_xfer(input logic [7:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] evt_cmp, input bit sd_cmp,
                          output logic [31:0] rdata, output bit err, output int waits,
                          output bit timeout, output bit tx_p, output bit rx_p);
    bit done;
    @(negedge pclk);
    bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wdata;
    bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    waits = 0; done = 0; rdata = '0; err = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.pready === 1'b1) begin
        rdata = bus.prdata; err = bus.pslverr; done = 1;
        evt = evt_cmp; sd = sd_cmp;
      end else begin
        waits++;
        @(negedge pclk);
      end
    end
    timeout = !done;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; evt = '0; sd = 1'b0;
    #1;
    tx_p = tx_winc; rx_p = rx_rinc;
  endtask

  task automatic pulse_core(input logic [3:0] e, input bit s, input bit r);
    @(negedge pclk);
    evt = e; sd = s; rd = r;
    @(negedge pclk);
    evt = '0; sd = 1'b0; rd = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    preset = 1'b1;
    bus.paddr = 8'h0C; bus.pwrite = 1'b1; bus.pwdata = 32'hFF;
    bus.psel = 1'b1; bus.penable = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk); #1;
    n_checks++; if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got %b want 0", bus.pready); end
    n_checks++; if (bus.pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", bus.pslverr); end
    n_checks++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got %h want 0", bus.prdata); end
    n_checks++; if ({tx_winc, rx_rinc, irq} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {tx_winc, rx_rinc, irq}); end
    n_checks++; if ({slave_addr, command, prescale, tx_data} !== 32'h0) begin n_fail++; $display("FAIL reset_regs got %h want 0", {slave_addr, command, prescale, tx_data}); end
    bus.psel = 1'b0; bus.penable = 1'b0;
    preset = 1'b0;
    m_slave = 0; m_cmd = 0; m_pre = 0; m_txd = 0; m_ist = 0; m_ien = 0;
  endtask

  task automatic test_slave_rw;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    apb_xfer(8'h0C, 1, 32'hA5, 4'h0, 0, rdat, err, w, to, txp, rxp);
    m_slave = 8'hA5;
    n_checks++; if (err !== 1'b0 || w != 0 || to) begin n_fail++; $display("FAIL slave_wr err=%b waits=%0d want 0/0", err, w); end
    apb_xfer(8'h0C, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (rdat !== 32'h000000A5) begin n_fail++; $display("FAIL slave_rd data got %h want 000000a5", rdat); end
    n_checks++; if (err !== 1'b0 || w != 0) begin n_fail++; $display("FAIL slave_rd err=%b waits=%0d want 0/0", err, w); end
    n_checks++; if (slave_addr !== 8'hA5) begin n_fail++; $display("FAIL slave_out got %h want a5", slave_addr); end
  endtask

  task automatic test_receive;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    status = 8'h00; rx_data = 8'h3C;
    apb_xfer(8'h04, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (w != RD_WAIT || to) begin n_fail++; $display("FAIL rx_waits got %0d want %0d", w, RD_WAIT); end
    n_checks++; if (rdat !== 32'h3C || err !== 1'b0) begin n_fail++; $display("FAIL rx_data got %h err %b want 3c/0", rdat, err); end
    n_checks++; if (rxp !== 1'b1) begin n_fail++; $display("FAIL rx_rinc_pulse got %b want 1", rxp); end
    @(negedge pclk); #1;
    n_checks++; if (rx_rinc !== 1'b0) begin n_fail++; $display("FAIL rx_rinc_width got %b want 0", rx_rinc); end
    status = 8'h02;
    apb_xfer(8'h04, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (err !== 1'b1 || rdat !== 32'h0 || rxp !== 1'b0) begin n_fail++; $display("FAIL rx_empty err=%b data=%h rinc=%b want 1/0/0", err, rdat, rxp); end
    status = 8'h00;
  endtask

  task automatic test_transmit;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    status = 8'h01;
    apb_xfer(8'h00, 1, 32'h11, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (err !== 1'b1 || txp !== 1'b0) begin n_fail++; $display("FAIL tx_full err=%b winc=%b want 1/0", err, txp); end
    n_checks++; if (tx_data !== m_txd) begin n_fail++; $display("FAIL tx_full_data got %h want %h", tx_data, m_txd); end
    status = 8'h00;
    apb_xfer(8'h00, 1, 32'hFFFF_FF11, 4'h0, 0, rdat, err, w, to, txp, rxp);
    m_txd = 8'h11;
    n_checks++; if (err !== 1'b0 || txp !== 1'b1) begin n_fail++; $display("FAIL tx_ok err=%b winc=%b want 0/1", err, txp); end
    n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL tx_data got %h want 11", tx_data); end
    @(negedge pclk); #1;
    n_checks++; if (tx_winc !== 1'b0) begin n_fail++; $display("FAIL tx_winc_width got %b want 0", tx_winc); end
  endtask

  task automatic test_command;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    apb_xfer(8'h10, 1, 32'h40, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (command !== 8'h40) begin n_fail++; $display("FAIL cmd_wr got %h want 40", command); end
    pulse_core(4'h0, 1, 0);
    n_checks++; if (command !== 8'h00) begin n_fail++; $display("FAIL cmd_start_clr got %h want 00", command); end
    apb_xfer(8'h10, 1, 32'h40, 4'h0, 1, rdat, err, w, to, txp, rxp);
    n_checks++; if (command !== 8'h40) begin n_fail++; $display("FAIL cmd_wr_wins got %h want 40", command); end
    pulse_core(4'h0, 1, 0);
    apb_xfer(8'h10, 1, 32'hC3, 4'h0, 0, rdat, err, w, to, txp, rxp);
    pulse_core(4'h0, 0, 1);
    n_checks++; if (command !== 8'h43) begin n_fail++; $display("FAIL cmd_reset_clr got %h want 43", command); end
    pulse_core(4'h0, 1, 0);
    n_checks++; if (command !== 8'h03) begin n_fail++; $display("FAIL cmd_start_clr2 got %h want 03", command); end
    m_cmd = 8'h03;
  endtask

  task automatic test_irq;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    apb_xfer(8'h1C, 1, 32'h4, 4'h0, 0, rdat, err, w, to, txp, rxp);
    m_ien = 4'h4;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b want 0", irq); end
    pulse_core(4'h4, 0, 0);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b want 1", irq); end
    apb_xfer(8'h18, 1, 32'h4, 4'h4, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %b want 1", irq); end
    apb_xfer(8'h18, 1, 32'h4, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got %b want 0", irq); end
    pulse_core(4'h3, 0, 0);
    apb_xfer(8'h18, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (rdat !== 32'h3 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked ist=%h irq=%b want 3/0", rdat, irq); end
    m_ist = 4'h3;
  endtask

  task automatic test_errors;
    logic [31:0] rdat; bit err, to, txp, rxp; int w;
    apb_xfer(8'h20, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (err !== 1'b1 || rdat !== 32'h0) begin n_fail++; $display("FAIL err_0x20 err=%b data=%h want 1/0", err, rdat); end
    apb_xfer(8'h02, 0, 32'h0, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (err !== 1'b1 || rdat !== 32'h0) begin n_fail++; $display("FAIL err_0x02 err=%b data=%h want 1/0", err, rdat); end
    apb_xfer(8'h0E, 1, 32'h99, 4'h0, 0, rdat, err, w, to, txp, rxp);
    n_checks++; if (err !== 1'b1 || slave_addr !== m_slave) begin n_fail++; $display("FAIL err_0x0e err=%b slave=%h want 1/%h", err, slave_addr, m_slave); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rdat;
    @(negedge pclk);
    bus.paddr = 8'h14; bus.pwrite = 1'b1; bus.pwdata = 32'h5E; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk); bus.penable = 1'b1; #1;
    n_checks++; if (bus.pready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready got %b want 1", bus.pready); end
    @(negedge pclk);
    bus.pwrite = 1'b0; bus.penable = 1'b0;
    @(negedge pclk); bus.penable = 1'b1; #1;
    rdat = bus.prdata;
    n_checks++; if (bus.pready !== 1'b1 || rdat !== 32'h5E) begin n_fail++; $display("FAIL b2b_rd ready=%b data=%h want 1/5e", bus.pready, rdat); end
    @(negedge pclk); bus.psel = 1'b0; bus.penable = 1'b0;
    m_pre = 8'h5E;
  endtask

  task automatic test_reset_abort;
    status = 8'h00;
    @(negedge pclk);
    bus.paddr = 8'h00; bus.pwrite = 1'b1; bus.pwdata = 32'h77; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk); bus.penable = 1'b1; preset = 1'b1; #1;
    n_checks++; if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0) begin n_fail++; $display("FAIL abort_ready ready=%b err=%b want 0/0", bus.pready, bus.pslverr); end
    @(negedge pclk); bus.psel = 1'b0; bus.penable = 1'b0; preset = 1'b0; #1;
    n_checks++; if (tx_winc !== 1'b0 || tx_data !== 8'h00 || prescale !== 8'h00) begin n_fail++; $display("FAIL abort_state winc=%b txd=%h pre=%h want 0/00/00", tx_winc, tx_data, prescale); end
    m_slave = 0; m_cmd = 0; m_pre = 0; m_txd = 0; m_ist = 0; m_ien = 0;
  endtask

  task automatic test_random;
    logic [7:0] addrs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                               8'h20, 8'h02, 8'h06, 8'h3C};
    logic [31:0] rdat, wd, e_rd; bit err, to, txp, rxp, wr, known, e_err; int w;
    logic [7:0] a; logic [3:0] e;
    for (int it = 0; it < 80; it++) begin
      a = addrs[$urandom_range(0, 11)];
      wr = $urandom_range(0, 1); wd = $urandom;
      status = 8'($urandom_range(0, 255)); rx_data = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      apb_xfer(a, wr, wd, e, 0, rdat, err, w, to, txp, rxp);
      known = (a < 8'h20) && (a % 4 == 0);
      e_err = !known || (wr && (a == 8'h04 || a == 8'h08)) ||
              (wr && a == 8'h00 && status[0]) || (!wr && a == 8'h04 && status[1]);
      e_rd = 0;
      if (!wr && !e_err) begin
        case (a)
          8'h04: e_rd = rx_data;      8'h08: e_rd = status;
          8'h0C: e_rd = m_slave;      8'h10: e_rd = m_cmd;
          8'h14: e_rd = m_pre;        8'h18: e_rd = m_ist;
          8'h1C: e_rd = m_ien;        default: e_rd = 0;
        endcase
      end
      if (wr && !e_err) begin
        case (a)
          8'h00: m_txd = wd[7:0];     8'h0C: m_slave = wd[7:0];
          8'h10: m_cmd = wd[7:0];     8'h14: m_pre = wd[7:0];
          8'h18: m_ist = m_ist & ~wd[3:0];
          8'h1C: m_ien = wd[3:0];     default: ;
        endcase
      end
      m_ist = m_ist | e;
      n_checks++; if (to) begin n_fail++; $display("FAIL rnd_timeout it=%0d addr=%h", it, a); end
      n_checks++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err it=%0d addr=%h wr=%b got %b want %b", it, a, wr, err, e_err); end
      n_checks++; if (w != ((!wr && a == 8'h04) ? RD_WAIT : 0)) begin n_fail++; $display("FAIL rnd_waits it=%0d addr=%h got %0d", it, a, w); end
      if (!wr) begin
        n_checks++; if (rdat !== e_rd) begin n_fail++; $display("FAIL rnd_rdata it=%0d addr=%h got %h want %h", it, a, rdat, e_rd); end
      end
      n_checks++; if (txp !== (wr && !e_err && a == 8'h00) || rxp !== (!wr && !e_err && a == 8'h04)) begin
        n_fail++; $display("FAIL rnd_strobe it=%0d addr=%h winc=%b rinc=%b", it, a, txp, rxp); end
      n_checks++; if ({slave_addr, command, prescale, tx_data} !== {m_slave, m_cmd, m_pre, m_txd}) begin
        n_fail++; $display("FAIL rnd_regs it=%0d got %h want %h", it, {slave_addr, command, prescale, tx_data}, {m_slave, m_cmd, m_pre, m_txd}); end
      n_checks++; if (irq !== |(m_ist & m_ien)) begin n_fail++; $display("FAIL rnd_irq it=%0d got %b want %b", it, irq, |(m_ist & m_ien)); end
    end
  endtask

  initial begin
    status = 8'h00; rx_data = 8'h00; evt = 4'h0; sd = 1'b0; rd = 1'b0;
    bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0; bus.psel = 1'b0; bus.penable = 1'b0;
    test_reset;
    test_slave_rw;
    test_receive;
    test_transmit;
    test_command;
    test_irq;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
